// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter onto a shared byte FIFO write port
// Tracks FIFO occupancy at acceptance time so producers are stalled before the FIFO can overflow.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         fifo_w_data,
  output logic                      fifo_w_en,
  input  logic                      fifo_r_en,
  output logic [LVL_W-1:0]          level,
  output logic                      full,
  output logic                      empty,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      underflow
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [3:0]        burst_cnt;

  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   scan_idx;
  logic              pick_found;
  logic              gnt_valid;
  logic              gnt_last;
  logic [DATA_W-1:0] gnt_data;
  logic              room;
  logic              xfer;
  logic              pop_ok;
  logic [3:0]        cnt_next;
  logic              hit_max;
  logic [ID_W-1:0]   rr_next;

  // First valid requester at or after rr_ptr in circular order.
  always_comb begin
    pick_id    = '0;
    scan_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready looks only at registered level: a same-cycle pop never opens a slot.
  assign room = (level < LVL_W'(DEPTH));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state == BURST) && (grant_id == ID_W'(i)) && req_valid[i] && room;
    end
  end

  assign xfer     = (state == BURST) && gnt_valid && room;
  assign pop_ok   = fifo_r_en && (level != '0);
  assign cnt_next = burst_cnt + 4'd1;
  assign hit_max  = (cnt_next == 4'(MAX_BURST));
  assign rr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      level       <= '0;
      fifo_w_en   <= 1'b0;
      fifo_w_data <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      underflow   <= 1'b0;
    end else begin
      fifo_w_en <= xfer;
      if (xfer) begin
        fifo_w_data <= gnt_data;
      end

      if (fifo_r_en && (level == '0)) begin
        underflow <= 1'b1;
      end
      if (xfer && !pop_ok) begin
        level <= level + LVL_W'(1);
      end else if (!xfer && pop_ok) begin
        level <= level - LVL_W'(1);
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= BURST;
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
          end
        end
        BURST: begin
          // Full stalls but never releases; only last, burst limit or withdrawal do.
          if (!gnt_valid || (xfer && (gnt_last || hit_max))) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= rr_next;
          end else if (xfer) begin
            burst_cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized and directed bench with a cycle-level reference model
module tb_fifo_write_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXB  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] fifo_w_data;
  logic          fifo_w_en;
  logic          fifo_r_en;
  logic [2:0]    level;
  logic          full;
  logic          empty;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          underflow;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_w_data(fifo_w_data),
    .fifo_w_en(fifo_w_en), .fifo_r_en(fifo_r_en), .level(level), .full(full),
    .empty(empty), .grant_valid(grant_valid), .grant_id(grant_id), .underflow(underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, how many bytes it has sent, where the
  // round-robin search starts, and how many bytes sit in the FIFO.
  bit m_known = 0;
  int m_busy, m_gid, m_cnt, m_rr, m_level, m_uf, m_wen, m_wdata;

  logic [8:0] pbuf [N][64];
  int  prd [N];
  int  pwr [N];
  int  acc_cnt [N];
  bit  en [N];
  int  gseq[$];
  int  wlog[$];
  bit  gv_prev;

  task automatic push_byte(input int i, input int d, input bit last);
    pbuf[i][pwr[i] % 64] = {last, 8'(d)};
    pwr[i]++;
  endtask

  task automatic clear_producers();
    for (int i = 0; i < N; i++) begin
      prd[i] = 0; pwr[i] = 0; acc_cnt[i] = 0; en[i] = 0;
    end
    gseq.delete();
    wlog.delete();
    gv_prev = 0;
  endtask

  task automatic tick();
    int  exp_rdy;
    int  xfer;
    int  pop_ok;
    bit  found;
    int  j;
    for (int i = 0; i < N; i++) begin
      if (en[i] && prd[i] != pwr[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i*DW +: DW]} = pbuf[i][prd[i] % 64];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    #1;
    exp_rdy = 0;
    if (m_known) begin
      for (int i = 0; i < N; i++)
        if (m_busy && m_gid == i && req_valid[i] && m_level < DEPTH) exp_rdy |= (1 << i);
      chk("req_ready", req_ready, exp_rdy);
      chk("grant_valid", grant_valid, m_busy);
      chk("grant_id", grant_id, m_gid);
      chk("level", level, m_level);
      chk("full", full, m_level == DEPTH);
      chk("empty", empty, m_level == 0);
      chk("underflow", underflow, m_uf);
      chk("fifo_w_en", fifo_w_en, m_wen);
      if (m_wen) chk("fifo_w_data", fifo_w_data, m_wdata);
      if (fifo_w_en) wlog.push_back(fifo_w_data);
      if (grant_valid && !gv_prev) gseq.push_back(grant_id);
      gv_prev = grant_valid;
    end

    if (!rst_n) begin
      m_known = 1; m_busy = 0; m_gid = 0; m_cnt = 0; m_rr = 0;
      m_level = 0; m_uf = 0; m_wen = 0; m_wdata = 0;
    end else if (m_known) begin
      xfer   = m_busy && ((exp_rdy >> m_gid) & 1);
      pop_ok = fifo_r_en && m_level > 0;
      m_wen  = xfer;
      if (xfer) m_wdata = req_data[m_gid*DW +: DW];
      if (fifo_r_en && m_level == 0) m_uf = 1;
      m_level = m_level + xfer - pop_ok;
      if (m_busy) begin
        if (!req_valid[m_gid] || (xfer && (req_last[m_gid] || m_cnt + 1 == MAXB))) begin
          m_busy = 0;
          m_rr   = (m_gid + 1) % N;
        end else if (xfer) begin
          m_cnt++;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!found && req_valid[j]) begin
            found = 1; m_busy = 1; m_gid = j; m_cnt = 0;
          end
        end
      end
    end

    for (int i = 0; i < N; i++)
      if ((exp_rdy >> i) & 1) begin
        prd[i]++;
        acc_cnt[i]++;
      end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_producers();
    fifo_r_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int exp_order [12];
  int waited;

  initial begin
    rst_n = 1'b0;
    fifo_r_en = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    clear_producers();
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // All valid out of reset, then reset in the middle of the burst.
    clear_producers();
    for (int i = 0; i < N; i++) begin
      en[i] = 1;
      for (int k = 0; k < 8; k++) push_byte(i, i*16 + k, 0);
    end
    chk("rst_empty", empty, 1);
    chk("rst_wdata", fifo_w_data, 0);
    tick();
    chk("first_gv", grant_valid, 1);
    chk("first_gid", grant_id, 0);
    tick();
    chk("first_wen", fifo_w_en, 1);
    chk("first_wdata", fifo_w_data, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_wen", fifo_w_en, 0);
    chk("midrst_gv", grant_valid, 0);
    chk("midrst_level", level, 0);

    // Requesters 0 and 2 each stream 6 bytes with continuous pops.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_byte(0, k, k == 5);
      push_byte(2, 32 + k, k == 5);
    end
    en[0] = 1; en[2] = 1; fifo_r_en = 1'b1;
    for (int t = 0; t < 40; t++) tick();
    for (int k = 0; k < 4; k++) begin
      exp_order[k] = k; exp_order[4+k] = 32 + k;
    end
    exp_order[8] = 4; exp_order[9] = 5; exp_order[10] = 36; exp_order[11] = 37;
    chk("order_count", wlog.size(), 12);
    for (int k = 0; k < 12; k++)
      if (k < wlog.size()) chk("order_byte", wlog[k], exp_order[k]);

    // Single-byte packets from everyone: grants rotate and wrap.
    do_reset();
    for (int i = 0; i < N; i++) begin
      en[i] = 1;
      for (int k = 0; k < 3; k++) push_byte(i, i*16 + k, 1);
    end
    fifo_r_en = 1'b1;
    for (int t = 0; t < 30; t++) tick();
    chk("rot_len_ok", gseq.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (k < gseq.size()) chk("rot_gid", gseq[k], k % N);

    // No pops: requester 1 fills the FIFO and stalls while holding the grant.
    do_reset();
    for (int k = 0; k < 8; k++) push_byte(1, 16 + k, k == 7);
    en[1] = 1;
    for (int t = 0; t < 15; t++) tick();
    chk("full_acc", acc_cnt[1], 4);
    chk("full_level", level, 4);
    chk("full_flag", full, 1);
    chk("full_ready", req_ready, 0);
    chk("full_gv", grant_valid, 1);
    fifo_r_en = 1'b1;
    tick();
    fifo_r_en = 1'b0;
    chk("pop_level", level, 3);
    tick();
    chk("refill_acc", acc_cnt[1], 5);
    chk("refill_level", level, 4);

    // Transfer and pop in one cycle at level 2, then underflow.
    do_reset();
    push_byte(0, 1, 0);
    push_byte(0, 2, 1);
    en[0] = 1;
    for (int t = 0; t < 6; t++) tick();
    chk("lvl2", level, 2);
    push_byte(3, 99, 1);
    en[3] = 1;
    tick();
    fifo_r_en = 1'b1;
    tick();
    fifo_r_en = 1'b0;
    chk("both_level", level, 2);
    chk("both_uf", underflow, 0);
    fifo_r_en = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    fifo_r_en = 1'b0;
    chk("uf_level", level, 0);
    chk("uf_set", underflow, 1);
    tick();
    tick();
    chk("uf_sticky", underflow, 1);

    // Requester 3 withdraws mid-burst; requester 0 is next.
    do_reset();
    for (int k = 0; k < 5; k++) push_byte(3, 48 + k, 0);
    en[3] = 1;
    waited = 0;
    while (acc_cnt[3] < 2 && waited < 20) begin
      tick();
      waited++;
    end
    chk("wd_wait", acc_cnt[3], 2);
    en[3] = 0;
    push_byte(0, 7, 1);
    en[0] = 1;
    for (int t = 0; t < 4; t++) tick();
    chk("wd_len", gseq.size(), 2);
    if (gseq.size() >= 2) begin
      chk("wd_first", gseq[0], 3);
      chk("wd_next", gseq[1], 0);
    end

    // Random traffic, pops and occasional resets against the model.
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (pwr[i] - prd[i] < 60 && $urandom_range(0, 9) < 3)
          push_byte(i, $urandom_range(0, 255), $urandom_range(0, 3) == 0);
        if (!en[i]) en[i] = ($urandom_range(0, 1) == 1);
        else if ($urandom_range(0, 29) == 0) en[i] = 0;
      end
      fifo_r_en = ($urandom_range(0, 9) < 4);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the single byte write port of the ECG/SPI byte FIFO among N_REQ producers, e.g. the ADC sample packer, the status/marker source and the debug source.
- Grants bursts, registers the selected byte onto the FIFO write port, and keeps an exact occupancy count.
- Back-pressures producers so the FIFO can never overflow.
- Sits between the producers and the FIFO. The FIFO read side runs on the same clock and reports pops through fifo_r_en.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
DEPTH, 4, FIFO capacity in bytes
MAX_BURST, 4, maximum bytes per grant before forced release (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  producer i has a byte
req_data  in  N_REQ*DATA_W  byte of producer i at bits [i*DATA_W +: DATA_W]
req_last  in  N_REQ  byte is the last of producer i's packet
req_ready  out  N_REQ  byte of producer i accepted this cycle when valid&ready
fifo_w_data  out  DATA_W  byte to FIFO
fifo_w_en  out  1  FIFO write strobe, one cycle per byte
fifo_r_en  in  1  consumer popped one byte this cycle
level  out  clog2(DEPTH+1)  bytes committed to FIFO (accepted, not yet popped)
full  out  1  level==DEPTH
empty  out  1  level==0
grant_valid  out  1  a burst is active
grant_id  out  clog2(N_REQ)  index of granted requester
underflow  out  1  sticky: fifo_r_en seen while level==0

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE, rr_ptr=0, burst count=0, level=0, fifo_w_en=0, fifo_w_data=0, grant_valid=0, grant_id=0, underflow=0, empty=1, full=0.
- Reset mid-burst aborts the burst. A registered write pending on that edge is dropped.
- State machine, two states:
  - IDLE: req_ready all 0. If any req_valid, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ. Next cycle: state=BURST, grant_id=pick, grant_valid=1, count=0. If no req_valid, stay in IDLE.
  - BURST: req_ready[grant_id] = req_valid[grant_id] & (level<DEPTH). req_ready is combinational from the registered state and level, and is 0 for every other index. Transfer = valid & ready of the granted requester.
  - On a transfer: count+1. Register fifo_w_data=req_data[grant_id] and fifo_w_en=1 on the next cycle, so write latency is 1 cycle. fifo_w_en=0 in every cycle with no transfer.
  - Release to IDLE at the clock edge ending a cycle in which any of these holds: the transfer carries req_last; the transfer makes count reach MAX_BURST; or req_valid[grant_id]=0 (producer withdrew).
  - On release: rr_ptr=(grant_id+1) mod N_REQ, grant_valid=0.
  - Full (level==DEPTH) does not release the grant. The grant holds with ready=0 until space frees.
  - Every grant costs at least one IDLE arbitration cycle, so there are no back-to-back grants.
- Level accounting:
  - Counted at acceptance time, not at fifo_w_en: transfer only → +1; fifo_r_en only with level>0 → −1; both → unchanged.
  - fifo_r_en with level==0: level stays 0 and underflow is set until reset.
  - level can never exceed DEPTH, because ready is gated on level<DEPTH.
  - A pop in the same cycle does not enable acceptance at level==DEPTH. Ready uses the registered level only, so there is no combinational path from fifo_r_en to req_ready.
- full and empty are decoded combinationally from the registered level.
- Fairness: the requester just served has the lowest priority at the next arbitration. With all N_REQ continuously valid, grants rotate 0,1,...,N_REQ−1,0.
- req_data and req_last of non-granted requesters are ignored. Producers must hold data stable while valid&!ready.

Test Plan:
- Reset with all req_valid=1 → grant_id=0 one cycle after the IDLE arbitration cycle; fifo_w_en rises 1 cycle after the first req_ready. Then assert rst_n=0 mid-burst → all outputs at reset values on the next edge, with no stray fifo_w_en.
- Requesters 0 and 2 each stream 6 bytes, last on byte 6, with fifo_r_en=1 every cycle; MAX_BURST=4 → FIFO write order: 0:b0–b3, 2:b0–b3, 0:b4–b5, 2:b4–b5; one idle cycle between bursts; FIFO contents match the per-requester byte order.
- All 4 requesters valid continuously, fifo_r_en=1, packets of length 1 → grant_id sequence 0,1,2,3,0,1 and rr_ptr wraps 3→0.
- fifo_r_en=0 with requester 1 streaming 8 bytes, last on byte 8 → exactly 4 accepted, level=4, full=1, req_ready=0, grant held. Then a single fifo_r_en pulse → level=3, one more byte accepted the next cycle, level back to 4.
- level=2 with a transfer and fifo_r_en in the same cycle → level stays 2. Then fifo_r_en with level=0 → level=0, underflow=1, held until reset.
- Requester 3 granted drops req_valid after 2 bytes (no last) → release to IDLE, rr_ptr=0, with requester 0 next if valid.
